// File: rtl/mem_access.sv
// MEM stage of the 64-bit RISC-V pipeline: doubleword load/store on an internal
// data memory with fixed access latency, branch resolution and WB registers.
module mem_access #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] Result_recieve,
    input  logic        Zero_recieve,
    input  logic [63:0] read_data_2_recieve,
    input  logic [63:0] pcbranch_recieve,
    input  logic        Mem_Write_recieve,
    input  logic        Mem_Read_recieve,
    input  logic        Mem_to_Reg_recieve,
    input  logic        Branch_recieve,
    input  logic        Reg_Write_recieve,
    input  logic [4:0]  rd_recieve,
    output logic        stall,
    output logic        out_valid,
    output logic [63:0] read_data,
    output logic [63:0] Result,
    output logic        Mem_to_Reg,
    output logic        Reg_Write,
    output logic [4:0]  rd,
    output logic        PCSrc,
    output logic [63:0] pcbranch,
    output logic        mem_fault
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [3:0]    cnt;
    logic [63:0]   mem [DEPTH];

    logic [63:0]   c_addr, c_data, c_pcbranch;
    logic          c_zero, c_write, c_read, c_m2r, c_branch, c_regwr;
    logic [4:0]    c_rd;
    logic [IW-1:0] c_idx;
    logic          c_fault, is_mem, done;
    logic          branch_q, zero_q;

    assign is_mem  = Mem_Read_recieve | Mem_Write_recieve;
    assign c_idx   = c_addr[3+IW-1:3];
    assign c_fault = (c_addr[2:0] != 3'd0) || (|c_addr[63:3+IW]) || (c_read && c_write);
    assign done    = (state == BUSY) && (cnt == '0);
    assign stall   = (state == BUSY);
    assign PCSrc   = out_valid & branch_q & zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && is_mem) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            c_addr     <= '0;
            c_data     <= '0;
            c_pcbranch <= '0;
            c_zero     <= 1'b0;
            c_write    <= 1'b0;
            c_read     <= 1'b0;
            c_m2r      <= 1'b0;
            c_branch   <= 1'b0;
            c_regwr    <= 1'b0;
            c_rd       <= '0;
            out_valid  <= 1'b0;
            read_data  <= '0;
            Result     <= '0;
            Mem_to_Reg <= 1'b0;
            Reg_Write  <= 1'b0;
            rd         <= '0;
            pcbranch   <= '0;
            mem_fault  <= 1'b0;
            branch_q   <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && is_mem) begin
                        cnt        <= 4'(MEM_LATENCY - 1);
                        c_addr     <= Result_recieve;
                        c_data     <= read_data_2_recieve;
                        c_pcbranch <= pcbranch_recieve;
                        c_zero     <= Zero_recieve;
                        c_write    <= Mem_Write_recieve;
                        c_read     <= Mem_Read_recieve;
                        c_m2r      <= Mem_to_Reg_recieve;
                        c_branch   <= Branch_recieve;
                        c_regwr    <= Reg_Write_recieve;
                        c_rd       <= rd_recieve;
                    end else if (in_valid) begin
                        Result     <= Result_recieve;
                        pcbranch   <= pcbranch_recieve;
                        Mem_to_Reg <= Mem_to_Reg_recieve;
                        Reg_Write  <= Reg_Write_recieve;
                        rd         <= rd_recieve;
                        branch_q   <= Branch_recieve;
                        zero_q     <= Zero_recieve;
                        read_data  <= '0;
                        mem_fault  <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        Result     <= c_addr;
                        pcbranch   <= c_pcbranch;
                        Mem_to_Reg <= c_m2r;
                        Reg_Write  <= c_regwr & ~(c_read & c_fault);
                        rd         <= c_rd;
                        branch_q   <= c_branch;
                        zero_q     <= c_zero;
                        read_data  <= (c_read && !c_fault) ? mem[c_idx] : '0;
                        mem_fault  <= c_fault;
                        out_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; the rst_n term keeps an aborted store from committing.
    always_ff @(posedge clk) begin
        if (rst_n && done && c_write && !c_fault) mem[c_idx] <= c_data;
    end
endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access against an array-based
// reference model, plus latency probes on MEM_LATENCY=1 and 4 instances.
module tb_mem_access;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, iv1 = 1'b0, iv4 = 1'b0;
    logic [63:0] res_in = '0, wdata_in = '0, pcb_in = '0;
    logic        zero_in = 1'b0, mw_in = 1'b0, mr_in = 1'b0, m2r_in = 1'b0;
    logic        br_in = 1'b0, rw_in = 1'b0;
    logic [4:0]  rd_in = '0;

    logic        stall, ov, m2r, rw, pcsrc, fault;
    logic [63:0] rdata, res, pcb;
    logic [4:0]  rd_o;

    logic        stall1, ov1, m2r1, rw1, pcsrc1, fault1;
    logic [63:0] rdata1, res1, pcb1;
    logic [4:0]  rd1;
    logic        stall4, ov4, m2r4, rw4, pcsrc4, fault4;
    logic [63:0] rdata4, res4, pcb4;
    logic [4:0]  rd4;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [DEPTH];
    int psel = 0;

    always #5 clk = ~clk;

    mem_access #(.DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Result_recieve(res_in), .Zero_recieve(zero_in), .read_data_2_recieve(wdata_in),
        .pcbranch_recieve(pcb_in), .Mem_Write_recieve(mw_in), .Mem_Read_recieve(mr_in),
        .Mem_to_Reg_recieve(m2r_in), .Branch_recieve(br_in), .Reg_Write_recieve(rw_in),
        .rd_recieve(rd_in), .stall(stall), .out_valid(ov), .read_data(rdata),
        .Result(res), .Mem_to_Reg(m2r), .Reg_Write(rw), .rd(rd_o), .PCSrc(pcsrc),
        .pcbranch(pcb), .mem_fault(fault));

    mem_access #(.DEPTH(DEPTH), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1),
        .Result_recieve(res_in), .Zero_recieve(zero_in), .read_data_2_recieve(wdata_in),
        .pcbranch_recieve(pcb_in), .Mem_Write_recieve(mw_in), .Mem_Read_recieve(mr_in),
        .Mem_to_Reg_recieve(m2r_in), .Branch_recieve(br_in), .Reg_Write_recieve(rw_in),
        .rd_recieve(rd_in), .stall(stall1), .out_valid(ov1), .read_data(rdata1),
        .Result(res1), .Mem_to_Reg(m2r1), .Reg_Write(rw1), .rd(rd1), .PCSrc(pcsrc1),
        .pcbranch(pcb1), .mem_fault(fault1));

    mem_access #(.DEPTH(DEPTH), .MEM_LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4),
        .Result_recieve(res_in), .Zero_recieve(zero_in), .read_data_2_recieve(wdata_in),
        .pcbranch_recieve(pcb_in), .Mem_Write_recieve(mw_in), .Mem_Read_recieve(mr_in),
        .Mem_to_Reg_recieve(m2r_in), .Branch_recieve(br_in), .Reg_Write_recieve(rw_in),
        .rd_recieve(rd_in), .stall(stall4), .out_valid(ov4), .read_data(rdata4),
        .Result(res4), .Mem_to_Reg(m2r4), .Reg_Write(rw4), .rd(rd4), .PCSrc(pcsrc4),
        .pcbranch(pcb4), .mem_fault(fault4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_fault(input logic [63:0] a, input logic r, input logic w);
        return (a % 8 != 0) || (a >= 64'(DEPTH * 8)) || (r && w);
    endfunction

    // One instruction through the LAT=2 instance, checked against the model.
    task automatic do_op(input string tag, input logic r, input logic w, input logic br,
                         input logic z, input logic m2, input logic rwe, input logic [4:0] rdv,
                         input logic [63:0] a, input logic [63:0] d, input logic [63:0] pb);
        logic        is_mem, flt;
        logic [63:0] exp_rd;
        int          k, sc, exp_lat;
        is_mem  = r | w;
        flt     = is_mem && model_fault(a, r, w);
        exp_rd  = (r && !flt) ? model[a / 8] : 64'd0;
        exp_lat = is_mem ? LAT : 0;
        if (w && !r && !flt) model[a / 8] = d;

        @(negedge clk);
        res_in = a; wdata_in = d; pcb_in = pb; mr_in = r; mw_in = w; br_in = br;
        zero_in = z; m2r_in = m2; rw_in = rwe; rd_in = rdv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0; sc = 0;
        while (!ov && k < 20) begin
            if (stall) sc++;
            @(posedge clk); #1;
            k++;
        end
        if (!ov) begin
            check({tag, "_timeout"}, 64'(ov), 64'd1);
            return;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check({tag, "_stallw"}, 64'(sc), 64'(exp_lat));
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_result"}, res, a);
        check({tag, "_fault"}, 64'(fault), 64'(flt));
        check({tag, "_regwr"}, 64'(rw), 64'(rwe & ~(r & flt)));
        check({tag, "_m2r"}, 64'(m2r), 64'(m2));
        check({tag, "_rd"}, 64'(rd_o), 64'(rdv));
        check({tag, "_pcb"}, pcb, pb);
        check({tag, "_pcsrc"}, 64'(pcsrc), 64'(br & z));
        @(posedge clk); #1;
        check({tag, "_ovdrop"}, 64'(ov), 64'd0);
        check({tag, "_pcsrc_drop"}, 64'(pcsrc), 64'd0);
        check({tag, "_hold"}, res, a);
    endtask

    function automatic logic p_ov();
        return (psel == 4) ? ov4 : ov1;
    endfunction
    function automatic logic p_stall();
        return (psel == 4) ? stall4 : stall1;
    endfunction

    task automatic probe(input int which, input logic r, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] exp_rd);
        int k, sc;
        psel = which;
        @(negedge clk);
        res_in = a; wdata_in = d; mr_in = r; mw_in = ~r; br_in = 1'b0; zero_in = 1'b0;
        rw_in = r; rd_in = 5'd7; m2r_in = r;
        if (which == 4) iv4 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; iv4 = 1'b0;
        k = 0; sc = 0;
        while (!p_ov() && k < 20) begin
            if (p_stall()) sc++;
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("lat%0d_edges", which), 64'(k), 64'(which));
        check($sformatf("lat%0d_stallw", which), 64'(sc), 64'(which));
        if (r) check($sformatf("lat%0d_rdata", which), (which == 4) ? rdata4 : rdata1, exp_rd);
    endtask

    initial begin
        logic [63:0] a, d, old;
        int          op, idx, sel;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ov", 64'(ov), 64'd0);
        check("rst_result", res, 64'd0);
        check("rst_pcsrc", 64'(pcsrc), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            do_op("init", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                  64'(i * 8), {$urandom, $urandom}, 64'd0);

        // Three back-to-back non-memory instructions.
        @(negedge clk);
        mr_in = 1'b0; mw_in = 1'b0; br_in = 1'b0; rw_in = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            res_in = 64'(i * 16);
            @(posedge clk); #1;
            check("b2b_ov", 64'(ov), 64'd1);
            check("b2b_result", res, 64'(i * 16));
            check("b2b_stall", 64'(stall), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_ovdrop", 64'(ov), 64'd0);

        do_op("st40", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
              64'h40, 64'hDEADBEEF_CAFEF00D, 64'd0);
        do_op("ld40", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 64'h40, 64'd0, 64'd0);
        check("ld40_value", rdata, 64'hDEADBEEF_CAFEF00D);
        do_op("ld_mis", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 64'h43, 64'd0, 64'd0);
        do_op("st_oor", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
              64'(DEPTH * 8), 64'h1234_5678_9ABC_DEF0, 64'd0);
        do_op("ld_after_oor", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 64'h0, 64'd0, 64'd0);
        do_op("illegal", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 64'h8,
              64'hFFFF_0000_FFFF_0000, 64'd0);
        do_op("ld_after_ill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 64'h8, 64'd0, 64'd0);
        do_op("br_taken", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'h1000);
        do_op("br_not", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'h2000);

        // Reset during a store's BUSY window must abort the write.
        old = model[5];
        @(negedge clk);
        res_in = 64'h28; wdata_in = ~old; mr_in = 1'b0; mw_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid_busy", 64'(stall), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_stall", 64'(stall), 64'd0);
        check("rstmid_ov", 64'(ov), 64'd0);
        check("rstmid_result", res, 64'd0);
        check("rstmid_rdata", rdata, 64'd0);
        check("rstmid_pcb", pcb, 64'd0);
        check("rstmid_fault", 64'(fault), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op("rstmid_reload", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 64'h28, 64'd0, 64'd0);
        check("rstmid_old", rdata, old);

        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 3));
            idx = int'($urandom_range(0, DEPTH - 1));
            sel = int'($urandom_range(0, 9));
            a = 64'(idx * 8);
            if (sel == 0) a = a | 64'($urandom_range(1, 7));
            if (sel == 1) a = a | (64'd1 << $urandom_range(3 + IW, 63));
            d = {$urandom, $urandom};
            do_op("rand", op == 1 || op == 3, op == 2 || op == 3, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a, d,
                  {$urandom, $urandom});
        end

        probe(1, 1'b0, 64'h18, 64'hA5A5_0101_5A5A_1010, 64'd0);
        probe(1, 1'b1, 64'h18, 64'd0, 64'hA5A5_0101_5A5A_1010);
        probe(4, 1'b0, 64'h18, 64'h0F0F_2222_F0F0_3333, 64'd0);
        probe(4, 1'b1, 64'h18, 64'd0, 64'h0F0F_2222_F0F0_3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
